// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterised multi-port register file with byte lanes, bypass and clear sweep
//
// Purpose:
//   DEPTH x WIDTH register file with NRD combinational read ports and one
//   byte-lane-masked write port. Optional hardwired-zero register 0 and
//   optional write-to-read forwarding. A clear request starts a sweep that
//   zeroes one entry per clock while busy is high.
//
// Ports:
//   clk      in   1          clock, rising edge
//   rst_n    in   1          synchronous active-low reset
//   we3      in   1          write enable
//   wa3      in   AW         write address
//   wd3      in   WIDTH      write data
//   wbe3     in   NB         byte-lane write enables
//   ra       in   NRD*AW     read addresses, port k at ra[k*AW +: AW]
//   rd       out  NRD*WIDTH  read data, port k at rd[k*WIDTH +: WIDTH]
//   clr_req  in   1          start a clear sweep
//   busy     out  1          clear sweep in progress

module regfile_param #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int NB     = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we3,
  input  logic [AW-1:0]        wa3,
  input  logic [WIDTH-1:0]     wd3,
  input  logic [NB-1:0]        wbe3,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 clr_req,
  output logic                 busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [AW-1:0]    r_ptr;

  logic             w_wr_ok;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign busy = (r_state == SWEEP);

  // A write is accepted only in IDLE with no competing clear; the same
  // qualifier gates forwarding so a dropped write is never visible.
  assign w_wr_ok = rst_n && we3 && !busy && !clr_req &&
                   in_range(wa3) && !is_zero_reg(wa3);

  assign w_old = in_range(wa3) ? r_mem[wa3] : '0;

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < NB; i++) begin
      if (wbe3[i]) w_merged[8*i +: 8] = wd3[8*i +: 8];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = ra[k*AW +: AW];
    assign rd[k*WIDTH +: WIDTH] =
        (!in_range(w_ra) || is_zero_reg(w_ra))          ? '0 :
        ((BYPASS != 0) && w_wr_ok && (w_ra == wa3))     ? w_merged :
                                                          r_mem[w_ra];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
          end else if (w_wr_ok) begin
            r_mem[wa3] <= w_merged;
          end
        end
        SWEEP: begin
          r_mem[r_ptr] <= '0;
          if (r_ptr == AW'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param

module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [3:0]  wbe3;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [63:0] rd_nb;
  logic        clr_req;
  logic        busy;
  logic        busy_nb;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3), .wbe3(wbe3),
    .ra(ra), .rd(rd), .clr_req(clr_req), .busy(busy)
  );

  regfile_param #(.ZERO_R0(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3), .wbe3(wbe3),
    .ra(ra), .rd(rd_nb), .clr_req(clr_req), .busy(busy_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we3 = 1'b1; wa3 = a; wd3 = d; wbe3 = be;
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'(i + 1) * 32'h01010101;
  endfunction

  initial begin
    rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; wbe3 = '0; ra = '0; clr_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_busy_nb", {31'd0, busy_nb}, 32'd0);
    for (int a = 0; a < 32; a += 9) begin
      set_ra(5'(a), 5'(31 - a));
      check("rst_rd0", rd[31:0], 32'd0);
      check("rst_rd1", rd[63:32], 32'd0);
      check("rst_nb_rd0", rd_nb[31:0], 32'd0);
    end

    // simple write, forwarding vs no forwarding
    wr(5'd2, 32'd12, 4'hF);
    set_ra(5'd2, 5'd3);
    check("byp_wr2", rd[31:0], 32'd12);
    check("nobyp_wr2", rd_nb[31:0], 32'd0);
    tick(); we3 = 1'b0; #1;
    check("rd_e2", rd[31:0], 32'd12);
    check("rd_e3", rd[63:32], 32'd0);
    check("nb_rd_e2", rd_nb[31:0], 32'd12);

    // byte-lane merge
    wr(5'd5, 32'hAABBCCDD, 4'hF);
    tick();
    wr(5'd5, 32'h11223344, 4'b0101);
    set_ra(5'd5, 5'd5);
    check("byp_merge", rd[31:0], 32'hAA22CC44);
    check("nobyp_old", rd_nb[31:0], 32'hAABBCCDD);
    tick(); we3 = 1'b0; #1;
    check("merge_e5", rd[31:0], 32'hAA22CC44);
    check("merge_e5_p1", rd[63:32], 32'hAA22CC44);
    check("nb_merge_e5", rd_nb[31:0], 32'hAA22CC44);

    // enable with no lanes selected
    wr(5'd5, 32'h0, 4'h0);
    #1;
    check("be0_byp", rd[31:0], 32'hAA22CC44);
    tick(); we3 = 1'b0; #1;
    check("be0_after", rd[31:0], 32'hAA22CC44);

    // register 0
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    set_ra(5'd0, 5'd0);
    check("r0_byp", rd[31:0], 32'd0);
    check("nb_r0_pre", rd_nb[31:0], 32'd0);
    tick(); we3 = 1'b0; #1;
    check("r0_after", rd[31:0], 32'd0);
    check("nb_r0_after", rd_nb[31:0], 32'hFFFFFFFF);

    // fill everything
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), fill_val(i), 4'hF);
      tick();
    end
    we3 = 1'b0;
    set_ra(5'd31, 5'd1);
    check("fill_31", rd[31:0], fill_val(31));
    check("fill_1", rd[63:32], fill_val(1));

    // clear and write in the same cycle: clear wins, no forwarding
    clr_req = 1'b1;
    wr(5'd7, 32'd9, 4'hF);
    set_ra(5'd7, 5'd31);
    check("clrwr_nobyp", rd[31:0], fill_val(7));
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      clr_req = (c == 5);
      #1;
      check("sweep_busy", {31'd0, busy}, 32'd1);
      check("sweep_e31", rd[63:32], fill_val(31));
      check("sweep_e7", rd[31:0], (c >= 8) ? 32'd0 : fill_val(7));
      tick();
    end
    clr_req = 1'b0;
    check("sweep_done", {31'd0, busy}, 32'd0);
    we3 = 1'b0;
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a), 5'(a));
      check("clr_rd0", rd[31:0], 32'd0);
      check("clr_rd1", rd[63:32], 32'd0);
      check("clr_nb", rd_nb[31:0], 32'd0);
    end

    // reset aborts a sweep
    wr(5'd20, 32'h2020, 4'hF); tick();
    wr(5'd31, 32'h3131, 4'hF); tick();
    we3 = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; clr_req = 1'b1;
    wr(5'd4, 32'h55, 4'hF);
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_busy_nb", {31'd0, busy_nb}, 32'd0);
    rst_n = 1'b1; clr_req = 1'b0; we3 = 1'b0;
    set_ra(5'd20, 5'd31);
    check("abort_e20", rd[31:0], 32'd0);
    check("abort_e31", rd[63:32], 32'd0);
    set_ra(5'd4, 5'd4);
    check("abort_e4", rd_nb[31:0], 32'd0);
    wr(5'd4, 32'h44, 4'hF);
    #1;
    check("post_rst_byp", rd[31:0], 32'h44);
    tick(); we3 = 1'b0; #1;
    check("post_rst_e4", rd[31:0], 32'h44);
    check("post_rst_nb_e4", rd_nb[31:0], 32'h44);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
